uart_wb_host: RTL

Bus-side initiator for the UART register block. After reset it programs the divisor latch, line, FIFO, interrupt-enable and modem-control registers. It then polls the line status register and moves bytes between valid/ready byte streams and the transmit/receive FIFOs. It sits between a byte-stream client (command processor, DMA) and the UART's 8-bit register port, replacing a CPU for headless links.

---
 rtl/uart_wb_host_if.sv | 26 ++
 rtl/uart_wb_host.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_host_if.sv
// Byte-wide register port between uart_wb_host (master) and the UART
// register block (slave). Strobes are single-cycle and read data is
// combinational, valid during the read strobe cycle.
interface uart_wb_host_if;
    logic [2:0] m_addr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_we_o;
    logic       m_re_o;

    modport master (
        output m_addr_o,
        output m_dat_o,
        output m_we_o,
        output m_re_o,
        input  m_dat_i
    );

    modport slave (
        input  m_addr_o,
        input  m_dat_o,
        input  m_we_o,
        input  m_re_o,
        output m_dat_i
    );
endinterface

// File: rtl/uart_wb_host.sv
// Headless bus initiator for the UART register block: programs the UART
// after reset, then polls LSR and moves bytes between valid/ready streams
// and the THR/RB registers with round-robin arbitration between rx and tx.
module uart_wb_host #(
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'hC0,
    parameter logic [3:0]  IER_VAL = 4'h0,
    parameter logic [4:0]  MCR_VAL = 5'h03,
    parameter int unsigned GAP     = 2
) (
    input  logic                  clk,
    input  logic                  wb_rst_ni,
    uart_wb_host_if.master        bus,
    input  logic [7:0]            tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [7:0]            rx_data_o,
    output logic [3:0]            rx_status_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  cfg_done_o
);

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [2:0] ADDR_RBTR = 3'd0;
    localparam logic [2:0] ADDR_LS   = 3'd5;
    localparam logic [2:0] CFG_LAST  = 3'd6;

    typedef enum logic [2:0] {
        S_CFG    = 3'd0,
        S_POLL   = 3'd1,
        S_DECIDE = 3'd2,
        S_RD_RB  = 3'd3,
        S_WR_THR = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t     state_r;
    logic [2:0] cfg_step_r;
    logic [3:0] wait_cnt_r;
    logic       rr_r;          // 1: tx wins the next tie, 0: rx wins
    logic       go_rx_r;       // rx side chosen at the last LSR read
    logic [3:0] lsr_err_r;     // {BI,FE,PE,OE} from the last LSR read
    logic       rx_cand_s;
    logic       tx_cand_s;
    logic       pick_tx_s;
    logic       pick_rx_s;

    // Register address of each configuration step; DLAB window first,
    // divisor high byte before low byte so the counter reloads fully.
    function automatic logic [2:0] cfg_addr(input logic [2:0] step);
        logic [2:0] a;
        case (step)
            3'd0:    a = 3'd3;
            3'd1:    a = 3'd1;
            3'd2:    a = 3'd0;
            3'd3:    a = 3'd3;
            3'd4:    a = 3'd2;
            3'd5:    a = 3'd1;
            3'd6:    a = 3'd4;
            default: a = 3'd0;
        endcase
        return a;
    endfunction

    // Write data of each configuration step.
    function automatic logic [7:0] cfg_data(input logic [2:0] step);
        logic [7:0] d;
        case (step)
            3'd0:    d = 8'h80 | LCR_VAL;
            3'd1:    d = DIVISOR[15:8];
            3'd2:    d = DIVISOR[7:0];
            3'd3:    d = LCR_VAL & 8'h7F;
            3'd4:    d = FCR_VAL | 8'h06;
            3'd5:    d = {4'h0, IER_VAL};
            3'd6:    d = {3'b000, MCR_VAL};
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // Arbitration on the LSR value presented during the POLL read strobe.
    always_comb begin
        rx_cand_s = bus.m_dat_i[0] & ~rx_valid_o;
        tx_cand_s = bus.m_dat_i[5] & tx_valid_i;
        if (rx_cand_s && tx_cand_s) begin
            pick_tx_s = rr_r;
        end else begin
            pick_tx_s = tx_cand_s;
        end
        pick_rx_s = rx_cand_s & ~pick_tx_s;
    end

    // Main sequencer: configuration, LSR polling and byte transfers, with all bus and stream outputs registered.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r      <= S_CFG;
            cfg_step_r   <= 3'd0;
            wait_cnt_r   <= 4'd0;
            rr_r         <= 1'b0;
            go_rx_r      <= 1'b0;
            lsr_err_r    <= 4'h0;
            bus.m_addr_o <= 3'd0;
            bus.m_dat_o  <= 8'h00;
            bus.m_we_o   <= 1'b0;
            bus.m_re_o   <= 1'b0;
            tx_ready_o   <= 1'b0;
            rx_data_o    <= 8'h00;
            rx_status_o  <= 4'h0;
            rx_valid_o   <= 1'b0;
            cfg_done_o   <= 1'b0;
        end else begin
            // Consumer handshake; a new byte captured in RD_RB overrides below.
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            case (state_r)
                S_CFG: begin
                    bus.m_we_o   <= 1'b1;
                    bus.m_addr_o <= cfg_addr(cfg_step_r);
                    bus.m_dat_o  <= cfg_data(cfg_step_r);
                    wait_cnt_r   <= GAP_LAST;
                    state_r      <= S_WAIT;
                end
                S_WAIT: begin
                    bus.m_we_o <= 1'b0;
                    bus.m_re_o <= 1'b0;
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else if (!cfg_done_o && (cfg_step_r != CFG_LAST)) begin
                        cfg_step_r <= cfg_step_r + 3'd1;
                        state_r    <= S_CFG;
                    end else begin
                        cfg_done_o   <= 1'b1;
                        bus.m_re_o   <= 1'b1;
                        bus.m_addr_o <= ADDR_LS;
                        state_r      <= S_POLL;
                    end
                end
                S_POLL: begin
                    bus.m_re_o <= 1'b0;
                    lsr_err_r  <= bus.m_dat_i[4:1];
                    tx_ready_o <= pick_tx_s;
                    go_rx_r    <= pick_rx_s;
                    state_r    <= S_DECIDE;
                end
                S_DECIDE: begin
                    tx_ready_o <= 1'b0;
                    go_rx_r    <= 1'b0;
                    if (tx_ready_o && tx_valid_i) begin
                        bus.m_we_o   <= 1'b1;
                        bus.m_addr_o <= ADDR_RBTR;
                        bus.m_dat_o  <= tx_data_i;
                        rr_r         <= 1'b0;
                        state_r      <= S_WR_THR;
                    end else if (go_rx_r) begin
                        bus.m_re_o   <= 1'b1;
                        bus.m_addr_o <= ADDR_RBTR;
                        rr_r         <= 1'b1;
                        state_r      <= S_RD_RB;
                    end else begin
                        wait_cnt_r <= GAP_LAST;
                        state_r    <= S_WAIT;
                    end
                end
                S_RD_RB: begin
                    bus.m_re_o  <= 1'b0;
                    rx_data_o   <= bus.m_dat_i;
                    rx_status_o <= lsr_err_r;
                    rx_valid_o  <= 1'b1;
                    wait_cnt_r  <= GAP_LAST;
                    state_r     <= S_WAIT;
                end
                S_WR_THR: begin
                    bus.m_we_o <= 1'b0;
                    wait_cnt_r <= GAP_LAST;
                    state_r    <= S_WAIT;
                end
                default: begin
                    bus.m_we_o <= 1'b0;
                    bus.m_re_o <= 1'b0;
                    tx_ready_o <= 1'b0;
                    go_rx_r    <= 1'b0;
                    wait_cnt_r <= GAP_LAST;
                    state_r    <= S_WAIT;
                end
            endcase
        end
    end

endmodule
